// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler owning a shared N:1 bit-select mux; holds each grant for up to BURST transfers.
// Define FIXED_PRIO_EN for fixed-priority arbitration (lowest index wins, search pointer pinned to 0).
module rr_mux_scheduler #(
  parameter int N     = 16,
  parameter int M     = $clog2(N),
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] inp,
  output logic [M-1:0] sel,
  output logic [N-1:0] grant,
  output logic         out_valid,
  output logic         out_data,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CW = $clog2(BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [M-1:0]  SEL_MAX  = M'(N - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e         state_q, state_d;
  logic [M-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   sel_q, sel_d;
  logic [N-1:0]   grant_q, grant_d;

  logic           found;
  logic [M-1:0]   winner;
  logic           transfer;

  // Index wrap uses N, not 2^M, so non-power-of-two N never selects past N-1.
  function automatic logic [M-1:0] wrap_idx(input int v);
    return M'((v >= N) ? v - N : v);
  endfunction

  assign busy      = (state_q == GRANT);
  assign out_valid = busy && req[sel_q];
  assign out_data  = busy && inp[sel_q];
  assign transfer  = out_valid && out_ready;
  assign sel       = sel_q;
  assign grant     = grant_q;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap_idx(int'(ptr_q) + i)]) begin
        found  = 1'b1;
        winner = wrap_idx(int'(ptr_q) + i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A dropped request releases without a transfer since out_valid is low that cycle.
        if (!req[sel_q] || (transfer && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          grant_d = '0;
          cnt_d   = '0;
          ptr_d   = (sel_q == SEL_MAX) ? '0 : sel_q + M'(1);
        end else if (transfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef FIXED_PRIO_EN
    ptr_d = '0;
`else
    ptr_d = ptr_d;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
    end
  end

endmodule
